// File: rtl/multicycle_control_fsm.sv
// Moore main control FSM for the multicycle RV32I datapath.
// Optional feature macro: MCCTRL_BNE_EN (enables bne resolution in BRANCH).
module multicycle_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic       InstrDone,
   output logic       Illegal
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      JAL      = 4'd8,
      ALUWB    = 4'd9,
      BRANCH   = 4'd10
   } state_t;

   state_t     state_r;
   state_t     next_state_s;
   state_t     out_state_s;
   logic       pcupdate_s;
   logic       branch_s;
   logic       taken_s;
   logic       illegal_op_s;

   // State register with synchronous reset into FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Opcode legality, shared by the DECODE transition and the Illegal pulse.
   always_comb begin
      case (op)
         OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR: illegal_op_s = 1'b0;
         default:                                 illegal_op_s = 1'b1;
      endcase
   end

   // Next-state logic.
   always_comb begin
      next_state_s = FETCH;
      case (state_r)
         FETCH:   next_state_s = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state_s = MEMADR;
               OP_R:         next_state_s = EXECR;
               OP_I:         next_state_s = EXECI;
               OP_JAL:       next_state_s = JAL;
               OP_BR:        next_state_s = BRANCH;
               default:      next_state_s = FETCH;
            endcase
         end
         MEMADR: begin
            if (op == OP_SW) begin
               next_state_s = MEMWRITE;
            end else begin
               next_state_s = MEMREAD;
            end
         end
         MEMREAD:  next_state_s = MEMWB;
         EXECR, EXECI, JAL: next_state_s = ALUWB;
         MEMWB, MEMWRITE, ALUWB, BRANCH: next_state_s = FETCH;
         default:  next_state_s = FETCH;
      endcase
   end

   // Branch condition; bne is only honoured when the feature macro is set.
   always_comb begin
      taken_s = 1'b0;
      case (funct3)
         3'b000:  taken_s = Zero;
`ifdef MCCTRL_BNE_EN
         3'b001:  taken_s = ~Zero;
`else
         3'b001:  taken_s = 1'b0;
`endif
         default: taken_s = 1'b0;
      endcase
   end

   // Immediate format follows the opcode, independent of state.
   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BR:   ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // During reset the decode sees FETCH so selects match FETCH; enables are masked below.
   assign out_state_s = reset ? FETCH : state_r;

   // Moore output decode with all signals defaulted to zero.
   always_comb begin
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      RegWrite   = 1'b0;
      InstrDone  = 1'b0;
      Illegal    = 1'b0;
      pcupdate_s = 1'b0;
      branch_s   = 1'b0;
      case (out_state_s)
         FETCH: begin
            IRWrite    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            pcupdate_s = 1'b1;
         end
         DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b01;
            InstrDone = illegal_op_s;
            Illegal   = illegal_op_s;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         ALUWB: begin
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pcupdate_s = 1'b1;
         end
         BRANCH: begin
            ALUSrcA   = 2'b10;
            ALUOp     = 2'b01;
            branch_s  = 1'b1;
            InstrDone = 1'b1;
         end
         default: begin
            IRWrite = 1'b0;
         end
      endcase
      if (reset) begin
         IRWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         InstrDone  = 1'b0;
         Illegal    = 1'b0;
         pcupdate_s = 1'b0;
         branch_s   = 1'b0;
      end else begin
         pcupdate_s = pcupdate_s;
      end
   end

   assign PCWrite = pcupdate_s | (branch_s & taken_s);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
// Expected output vectors are hand-written per state.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .InstrDone(InstrDone), .Illegal(Illegal)
   );

   // Packed as {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite,InstrDone,Illegal}
   logic [14:0] obs;
   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUOp, RegWrite, InstrDone, Illegal};

   localparam logic [14:0] V_RST    = 15'b0_0_0_0_10_00_10_00_0_0_0;
   localparam logic [14:0] V_FETCH  = 15'b1_0_0_1_10_00_10_00_0_0_0;
   localparam logic [14:0] V_DEC    = 15'b0_0_0_0_00_01_01_00_0_0_0;
   localparam logic [14:0] V_DECILL = 15'b0_0_0_0_00_01_01_00_0_1_1;
   localparam logic [14:0] V_MEMADR = 15'b0_0_0_0_00_10_01_00_0_0_0;
   localparam logic [14:0] V_MEMRD  = 15'b0_1_0_0_00_00_00_00_0_0_0;
   localparam logic [14:0] V_MEMWB  = 15'b0_0_0_0_01_00_00_00_1_1_0;
   localparam logic [14:0] V_MEMWR  = 15'b0_1_1_0_00_00_00_00_0_1_0;
   localparam logic [14:0] V_EXECR  = 15'b0_0_0_0_00_10_00_10_0_0_0;
   localparam logic [14:0] V_EXECI  = 15'b0_0_0_0_00_10_01_10_0_0_0;
   localparam logic [14:0] V_JAL    = 15'b1_0_0_0_00_01_10_00_0_0_0;
   localparam logic [14:0] V_ALUWB  = 15'b0_0_0_0_00_00_00_00_1_1_0;
   localparam logic [14:0] V_BRT    = 15'b1_0_0_0_00_10_00_01_0_1_0;
   localparam logic [14:0] V_BRN    = 15'b0_0_0_0_00_10_00_01_0_1_0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic chk_imm(input string tag, input logic [1:0] e);
      checks++;
      assert (ImmSrc === e) else begin
         errors++;
         $error("FAIL %s ImmSrc observed=%b expected=%b", tag, ImmSrc, e);
      end
   endtask

   initial begin
      reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; Zero = 1'b0;
      step(); step();
      chk("reset_init", obs, V_RST);
      reset = 1'b0; #1;
      chk("fetch_after_init", obs, V_FETCH);

      // lw: F D MEMADR MEMREAD MEMWB, then reset held two cycles in MEMWB
      step(); chk("lw_decode", obs, V_DEC); chk_imm("lw_imm", 2'b00);
      step(); chk("lw_memadr", obs, V_MEMADR);
      step(); chk("lw_memread", obs, V_MEMRD);
      step(); chk("lw_memwb", obs, V_MEMWB);
      reset = 1'b1; #1;
      chk("reset_in_memwb", obs, V_RST);
      step(); chk("reset_cycle1", obs, V_RST);
      step(); chk("reset_cycle2", obs, V_RST);
      reset = 1'b0; #1;
      chk("fetch_after_release", obs, V_FETCH);

      // sw: 4 cycles, MemWrite once
      op = 7'b0100011; #1; chk_imm("sw_imm", 2'b01);
      step(); chk("sw_decode", obs, V_DEC);
      step(); chk("sw_memadr", obs, V_MEMADR);
      step(); chk("sw_memwrite", obs, V_MEMWR);
      step(); chk("sw_back_fetch", obs, V_FETCH);

      // R-type
      op = 7'b0110011;
      step(); chk("r_decode", obs, V_DEC);
      step(); chk("r_execr", obs, V_EXECR);
      step(); chk("r_aluwb", obs, V_ALUWB);
      step(); chk("r_back_fetch", obs, V_FETCH);

      // I-type
      op = 7'b0010011; #1; chk_imm("i_imm", 2'b00);
      step(); step(); chk("i_execi", obs, V_EXECI);
      step(); chk("i_aluwb", obs, V_ALUWB);
      step(); chk("i_back_fetch", obs, V_FETCH);

      // jal
      op = 7'b1101111; #1; chk_imm("jal_imm", 2'b11);
      step(); step(); chk("jal_state", obs, V_JAL);
      step(); chk("jal_aluwb", obs, V_ALUWB);
      step(); chk("jal_back_fetch", obs, V_FETCH);

      // beq taken / not taken
      op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1; #1; chk_imm("br_imm", 2'b10);
      step(); chk("beq_decode", obs, V_DEC);
      step(); chk("beq_taken", obs, V_BRT);
      step(); chk("beq_t_fetch", obs, V_FETCH);
      Zero = 1'b0;
      step(); step(); chk("beq_not_taken", obs, V_BRN);
      step(); chk("beq_nt_fetch", obs, V_FETCH);

      // funct3=001 with Zero=0
      funct3 = 3'b001;
      step(); step();
`ifdef MCCTRL_BNE_EN
      chk("bne_zero0", obs, V_BRT);
`else
      chk("bne_zero0", obs, V_BRN);
`endif
      Zero = 1'b1; #1;
      chk("bne_zero1", obs, V_BRN);
      step(); chk("bne_back_fetch", obs, V_FETCH);

      // illegal opcode: 2 cycles
      op = 7'b1111111; funct3 = 3'b000; Zero = 1'b0; #1; chk_imm("ill_imm", 2'b00);
      step(); chk("ill_decode", obs, V_DECILL);
      step(); chk("ill_back_fetch", obs, V_FETCH);

      // reset mid-instruction in EXECR aborts to FETCH
      op = 7'b0110011;
      step(); step(); chk("abort_execr", obs, V_EXECR);
      reset = 1'b1; #1; chk("abort_reset_held", obs, V_RST);
      step(); reset = 1'b0; #1; chk("abort_fetch", obs, V_FETCH);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the multicycle RV32I datapath: a Moore state machine that sequences each instruction through Fetch, Decode and execute/writeback states. It drives datapath enables and mux selects, and produces the 2-bit `ALUOp` consumed by the ALU function decoder, which resolves `ALUOp`/`funct3`/`funct7b5` into `ALUControl`. It sits beside that decoder in the controller and receives `op`, `funct3` and `Zero` from the instruction register and ALU.

## Interface
No parameters.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `op` input 7: opcode field of the instruction register.
- `funct3` input 3: used only for branch resolution.
- `Zero` input 1: ALU zero flag.
- `PCWrite` output 1: PC register enable.
- `AdrSrc` output 1: memory address select (0 = PC, 1 = ALU result).
- `MemWrite` output 1: data memory write enable.
- `IRWrite` output 1: instruction/OldPC register enable.
- `ResultSrc` output 2: result mux (00 ALUOut, 01 Data, 10 ALUResult).
- `ALUSrcA` output 2: ALU A mux (00 PC, 01 OldPC, 10 rs1).
- `ALUSrcB` output 2: ALU B mux (00 rs2, 01 ImmExt, 10 constant 4).
- `ALUOp` output 2: 00 add, 01 subtract, 10 use funct fields.
- `ImmSrc` output 2: immediate format.
- `RegWrite` output 1: register file write enable.
- `InstrDone` output 1: one-cycle pulse on the last cycle of each instruction.
- `Illegal` output 1: one-cycle pulse in Decode for an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, ALUWB, BRANCH.
- All outputs are decoded from the state only, except:
  - `PCWrite` = PCUpdate | (Branch & taken).
  - `ImmSrc` is decoded from `op`.
- Every signal not listed for a state is 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precomputed).
  - MEMADR and EXECI: ALUSrcA=10, ALUSrcB=01. MEMADR uses ALUOp=00; EXECI uses ALUOp=10.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw (0000011) or sw (0100011).
  - DECODE→EXECR for 0110011, EXECI for 0010011, JAL for 1101111, BRANCH for 1100011.
  - DECODE→FETCH for any other opcode, with `Illegal`=1.
  - MEMADR→MEMREAD for lw, MEMWRITE for sw. MEMREAD→MEMWB.
  - EXECR, EXECI and JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH→FETCH.
- `ImmSrc`: 00 for lw and I-type, 01 for sw, 10 for branch, 11 for jal, 00 otherwise.
- `InstrDone`=1 in MEMWB, MEMWRITE, ALUWB and BRANCH, and in DECODE on an illegal opcode.
- Branch resolution: taken = Zero when funct3=000 (beq). Any other funct3 is not taken unless the Configuration macro enables it.

## Timing
- Reset:
  - A rising edge with `reset`=1 loads FETCH.
  - While `reset`=1, PCWrite, IRWrite, MemWrite, RegWrite, InstrDone and Illegal are forced to 0 regardless of state. Other outputs take their FETCH values.
  - Reset asserted mid-instruction aborts it at the next edge. No further enable pulses are produced.
- Cycle counts from FETCH to next FETCH: lw 5, sw 4, R 4, I 4, jal 4, branch 3, illegal 2.
- `Zero` is sampled combinationally in BRANCH only. It is don't-care elsewhere.
- `op` must be stable from DECODE through the instruction's final state; IR is written only in FETCH.

## Configuration
- `MCCTRL_BNE_EN` defined: in BRANCH, funct3=001 gives taken = ~Zero (bne).
- Without it: funct3=001 is never taken. It still spends 3 cycles and asserts no Illegal.

## Test plan
- Reset held 2 cycles in MEMWB state → state FETCH, RegWrite=0 during reset, IRWrite=1 on the first cycle after release.
- lw (op=0000011) → states F, D, MEMADR, MEMREAD, MEMWB. ImmSrc=00. RegWrite=1 only in cycle 5. InstrDone pulses once.
- sw then R-type add (op=0110011) → MemWrite=1 exactly 1 cycle with AdrSrc=1. EXECR shows ALUOp=10, ALUSrcB=00.
- beq with Zero=1 → PCWrite=1 in BRANCH, ALUOp=01. The same with Zero=0 gives PCWrite=0. Both return to FETCH after 3 cycles.
- funct3=001 with Zero=0 → PCWrite=1 with the macro defined and 0 without it.
- op=1111111 → Illegal=1 and InstrDone=1 in DECODE. No RegWrite or MemWrite. FETCH on the next cycle.
